uart_tx: RTL and testbench
==========================

# uart_tx

Transmit half of the board UART link: accepts bytes from the core over a valid/ready handshake, buffers them in a small FIFO and serialises each byte on `txd` as an 8N1 frame (start bit, 8 data bits LSB-first, stop bit). Bit timing uses the same `CLK_PER_HALF_BIT` convention as the receive side, so both ends of the link share one baud parameter. It sits between the core's output port and the board TX pin; the host loader and console output both go through it.

## Interface

- `CLK_PER_HALF_BIT`, 30, half bit period in clocks; one bit = `BIT` = 2*CLK_PER_HALF_BIT clocks; must be >= 1
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, >= 2

- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `tx_valid`  in  1  core offers `tx_data` this cycle
- `tx_data`  in  8  byte to send
- `tx_ready`  out  1  FIFO can accept; byte accepted on any edge with `tx_valid & tx_ready`
- `txd`  out  1  serial line, idle high, registered
- `busy`  out  1  FIFO non-empty or frame in progress
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered (not counting the frame on the wire)

## Operation

- Reset: `txd`=1, `busy`=0, `count`=0, `tx_ready`=1, FIFO pointers 0, FSM in IDLE, bit counter 0, clock counter 0.
- FIFO: circular buffer, write/read pointers one bit wider than index; `count` = wptr - rptr (modular). `tx_ready` = (count != FIFO_DEPTH), combinational from registered state only; it does not anticipate a same-cycle pop.
- Push and pop on the same edge: both take effect, `count` unchanged. Push while full: impossible by handshake (`tx_valid` with `tx_ready`=0 ignored, data dropped, no state change).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If count != 0: pop head into 8-bit shift register, drive `txd`<=0, clear clock counter, go START.
  - START: after BIT clocks, `txd`<=shift[0], bit index 0, go DATA.
  - DATA: every BIT clocks shift right; after bit index 7 has been held BIT clocks, `txd`<=1, go STOP.
  - STOP: after BIT clocks: if count != 0, pop next byte, `txd`<=0, go START directly (no idle gap); else go IDLE.
- Clock counter: counts 0..BIT-1 within every bit, wraps to 0 at each bit boundary; width sized for BIT-1.
- `busy` = (state != IDLE) | (count != 0), combinational.
- Reset mid-frame: next edge forces `txd`=1, discards in-flight byte and FIFO contents; no partial frame completes.

## Timing

- Byte accepted on edge t into empty FIFO with FSM in IDLE: pop at edge t+1, `txd` falls after edge t+1 (1-cycle latency).
- Each bit is held exactly BIT clocks; a frame is exactly 10*BIT clocks from `txd` fall to end of stop bit.
- Back-to-back frames: next start bit falls exactly 10*BIT clocks after previous start bit; continuous stream has no gaps.
- `tx_ready` rises on the edge after the pop that frees a full FIFO.
- `txd` changes only on clock edges; no glitches (register output directly).

## Test plan

- CLK_PER_HALF_BIT=4 (BIT=8): send 0x55 into idle block -> `txd` low one cycle after accept, sampled mid-bit sequence 0,1,0,1,0,1,0,1,0,1; frame 80 clocks; `busy` drops on the edge returning to IDLE.
- Loopback: connect `txd` to receive side with same parameter, send 0x00, 0xFF, 0xA3, 0x3C -> receiver reports same four bytes in order, no framing error.
- Burst of FIFO_DEPTH+1=5 bytes with `tx_valid` held high: 5 bytes accepted, `tx_ready` low once 4 buffered while the 1st is on the wire, 5 frames contiguous, start bits exactly 80 clocks apart.
- Full FIFO with `tx_valid`=1 during pop edge: `tx_ready` still 0 that cycle, byte not taken; taken next cycle; `count` never exceeds 4.
- Reset asserted mid-DATA of 0x0F with 2 bytes queued -> next edge `txd`=1, `count`=0, `busy`=0; no further frames.
- Edge parameter CLK_PER_HALF_BIT=1 (BIT=2): 0x81 -> 20-clock frame, bits correct.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit side: byte FIFO behind a valid/ready port, serialised as 8N1 frames on txd.
// Bit timing shares the CLK_PER_HALF_BIT convention with the receive side.
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 30,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int BIT = 2 * CLK_PER_HALF_BIT;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(BIT);

    localparam logic [PW-1:0] FULL     = PW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CLK = CW'(BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [1:0]    state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          has_data;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count    = wptr - rptr;
    assign has_data = (count != '0);
    assign tx_ready = (count != FULL);
    assign busy     = (state != IDLE) || has_data;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign pop      = has_data && ((state == IDLE) || (state == STOP && bit_end));

    // NOTE: the storage array is not reset; pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            txd     <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            clk_cnt <= '0;
        end else begin
            clk_cnt <= (state == IDLE || bit_end) ? '0 : clk_cnt + CW'(1);
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (has_data) begin
                        shift <= mem[rptr[AW-1:0]];
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd     <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Chain straight into the next start bit so a stream has no idle gap.
                    if (bit_end) begin
                        if (has_data) begin
                            shift <= mem[rptr[AW-1:0]];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes txd frames.
module tb_uart_tx;
    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid_a = 1'b0;
    logic       tx_valid_b = 1'b0;
    logic [7:0] tx_data_a = 8'h00;
    logic [7:0] tx_data_b = 8'h00;
    logic       tx_ready_a, tx_ready_b;
    logic       txd_a, txd_b;
    logic       busy_a, busy_b;
    logic [2:0] count_a, count_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   rst_gen = 0;
    int   max_cnt = 0;
    int   frames [2] = '{0, 0};

    uart_tx #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(4)) dut_a (
        .clock(clock), .reset(reset), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(tx_ready_a), .txd(txd_a), .busy(busy_a), .count(count_a)
    );

    uart_tx #(.CLK_PER_HALF_BIT(1), .FIFO_DEPTH(4)) dut_b (
        .clock(clock), .reset(reset), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(tx_ready_b), .txd(txd_b), .busy(busy_b), .count(count_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (!reset && int'(count_a) > max_cnt) max_cnt = int'(count_a);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic txd_of(input int id);
        return (id == 0) ? txd_a : txd_b;
    endfunction

    function automatic logic ready_of(input int id);
        return (id == 0) ? tx_ready_a : tx_ready_b;
    endfunction

    function automatic logic busy_of(input int id);
        return (id == 0) ? busy_a : busy_b;
    endfunction

    // Receiver model: samples each bit at mid-bit on falling clock edges.
    task automatic monitor(input int id, input int bitc);
        logic [7:0] got;
        logic       start_lvl;
        logic       stop_lvl;
        int         start_c;
        int         gen;
        int         last_start;
        exp_t       e;
        last_start = -1000000;
        forever begin
            @(negedge clock);
            if (reset || txd_of(id) !== 1'b0) continue;
            start_c = cyc;
            gen     = rst_gen;
            repeat (bitc / 2 - 1) @(negedge clock);
            start_lvl = txd_of(id);
            for (int k = 0; k < 8; k++) begin
                repeat (bitc) @(negedge clock);
                got[k] = txd_of(id);
            end
            repeat (bitc) @(negedge clock);
            stop_lvl = txd_of(id);
            repeat (bitc / 2) @(negedge clock);
            if (gen != rst_gen) continue;
            frames[id]++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d unexpected frame: got byte 0x%02h, none expected", id, got);
            end else begin
                if (id == 0) e = q_a.pop_front();
                else         e = q_b.pop_front();
                check($sformatf("dut%0d start bit", id), start_lvl, 0);
                check($sformatf("dut%0d data", id), got, e.data);
                check($sformatf("dut%0d stop bit", id), stop_lvl, 1);
                if (e.contig)
                    check($sformatf("dut%0d start spacing", id), start_c - last_start, 10 * bitc);
            end
            last_start = start_c;
        end
    endtask

    initial monitor(0, 8);
    initial monitor(1, 2);

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input int id, input logic [7:0] b, input bit contig);
        int waited = 0;
        if (id == 0) begin tx_valid_a = 1'b1; tx_data_a = b; end
        else         begin tx_valid_b = 1'b1; tx_data_b = b; end
        while (ready_of(id) !== 1'b1 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check($sformatf("dut%0d ready to accept 0x%02h", id, b), ready_of(id), 1);
        if (ready_of(id) === 1'b1) begin
            if (id == 0) q_a.push_back('{b, contig});
            else         q_b.push_back('{b, contig});
            @(posedge clock);
        end
        @(negedge clock);
        if (id == 0) tx_valid_a = 1'b0;
        else         tx_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        while (busy_of(id) !== 1'b0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("dut%0d returns idle", id), busy_of(id), 0);
        repeat (20) @(negedge clock);
    endtask

    initial begin
        int n;
        int frames_snap;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset txd", txd_a, 1);
        check("reset busy", busy_a, 0);
        check("reset count", count_a, 0);
        check("reset tx_ready", tx_ready_a, 1);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single 0x55 into an idle block
        send(0, 8'h55, 1'b0);
        check("t1 txd high right after accept", txd_a, 1);
        check("t1 count after accept", count_a, 1);
        @(negedge clock);
        check("t1 txd falls one cycle later", txd_a, 0);
        check("t1 count after pop", count_a, 0);
        repeat (79) @(negedge clock);
        check("t1 stop bit at clock 79", txd_a, 1);
        check("t1 busy through stop bit", busy_a, 1);
        @(negedge clock);
        check("t1 busy drops after 80 clocks", busy_a, 0);
        wait_idle(0);

        // Loopback patterns
        send(0, 8'h00, 1'b0);
        send(0, 8'hFF, 1'b1);
        send(0, 8'hA3, 1'b1);
        send(0, 8'h3C, 1'b1);
        wait_idle(0);
        check("t2 all frames received", q_a.size(), 0);

        // Burst of FIFO_DEPTH+1 with valid held, then a push attempt against a full FIFO
        send(0, 8'h01, 1'b0);
        send(0, 8'h02, 1'b1);
        send(0, 8'h03, 1'b1);
        send(0, 8'h04, 1'b1);
        send(0, 8'h05, 1'b1);
        check("t3 count full", count_a, 4);
        check("t3 tx_ready low when full", tx_ready_a, 0);
        tx_valid_a = 1'b1;
        tx_data_a  = 8'hC7;
        n = 0;
        while (tx_ready_a !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t3 count after pop, offered byte not taken", count_a, 3);
        check("t3 next start bit on pop edge", txd_a, 0);
        send(0, 8'hC7, 1'b1);
        check("t3 count refilled", count_a, 4);
        wait_idle(0);
        check("t3 all frames received", q_a.size(), 0);

        // Minimum bit period
        send(1, 8'h81, 1'b0);
        check("t4 txd high right after accept", txd_b, 1);
        @(negedge clock);
        check("t4 txd falls one cycle later", txd_b, 0);
        repeat (19) @(negedge clock);
        check("t4 stop bit at clock 19", txd_b, 1);
        check("t4 busy through stop bit", busy_b, 1);
        @(negedge clock);
        check("t4 busy drops after 20 clocks", busy_b, 0);
        wait_idle(1);
        check("t4 frame received", q_b.size(), 0);

        // Reset during DATA of 0x0F with two bytes queued
        send(0, 8'h0F, 1'b0);
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        check("t5 two bytes queued", count_a, 2);
        repeat (41) @(negedge clock);
        check("t5 mid data bit 4 of 0x0F", txd_a, 0);
        reset = 1'b1;
        rst_gen++;
        q_a.delete();
        @(negedge clock);
        check("t5 txd forced high", txd_a, 1);
        check("t5 count cleared", count_a, 0);
        check("t5 busy cleared", busy_a, 0);
        check("t5 tx_ready after reset", tx_ready_a, 1);
        @(negedge clock);
        reset = 1'b0;
        frames_snap = frames[0];
        repeat (200) @(negedge clock);
        check("t5 no frames after reset", frames[0], frames_snap);
        check("t5 line idle after reset", txd_a, 1);
        check("t5 still not busy", busy_a, 0);

        check("count never exceeds depth", max_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
